// File: rtl/sample_feeder_pkg.sv
// Shared types and default widths for the sample_feeder training-data responder.
package sample_feeder_pkg;

    localparam int unsigned X_W_DEF    = 16;
    localparam int unsigned DEPTH_DEF  = 64;
    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned EPOCH_W    = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        READY = 2'd2
    } state_t;

    // One training sample; bit layout matches the RAM word {x1, x2, t}.
    typedef struct packed {
        logic [X_W_DEF-1:0] x1;
        logic [X_W_DEF-1:0] x2;
        logic               t;
    } sample_t;

endpackage

// File: rtl/sample_feeder_mem.sv
// Sample store: DEPTH x W single-write-port RAM with a registered read port.
// Ports:
//   clk, rst            clock, synchronous active-high reset (read register only)
//   we, wr_addr, wr_data   write port
//   re, rd_addr         read request; rd_data updates on the next edge
//   rd_data             registered read data, holds between reads
module sample_feeder_mem
    import sample_feeder_pkg::*;
#(
    parameter int unsigned W      = 2 * X_W_DEF + 1,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem [DEPTH];

    // Array write, no reset: contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port; reset clears the served sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// sample_feeder: serves preloaded training samples {x1, x2, t} to the trainer's
// getData strobe, one per req with one-cycle latency, wrapping each epoch.
// Optional feature macro: SAMPLE_FEEDER_EPOCH_CNT_EN adds the epoch_cnt output.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   clear                      empty the store, back to EMPTY (highest priority)
//   wr_en, wr_x1, wr_x2, wr_t  host sample write at the fill pointer
//   commit                     close fill phase, enter READY
//   req, rewind                fetch next sample / restart at sample 0
//   x1_out, x2_out, t_out      served sample (held between serves)
//   valid, last                one-cycle serve pulse, last-of-epoch flag
//   ready, n_out               READY state, stored sample count
//   epoch_cnt                  (optional) completed-epoch counter, saturating
//   err                        sticky protocol error
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int unsigned X_W    = X_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [X_W-1:0]     wr_x1,
    input  logic [X_W-1:0]     wr_x2,
    input  logic               wr_t,
    input  logic               commit,
    input  logic               req,
    input  logic               rewind,
    output logic [X_W-1:0]     x1_out,
    output logic [X_W-1:0]     x2_out,
    output logic               t_out,
    output logic               valid,
    output logic               last,
    output logic               ready,
    output logic [ADDR_W:0]    n_out,
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
    output logic [EPOCH_W-1:0] epoch_cnt,
`endif
    output logic               err
);

    localparam int unsigned W = 2 * X_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] rptr;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              at_end_c;
    logic              rd_en_c;
    logic              wr_ok_c;
    logic [W-1:0]      rd_data;

    // Read address honours a same-cycle rewind; the write pointer is n_out itself.
    always_comb begin
        rd_addr_c = rewind ? '0 : rptr;
        at_end_c  = ({1'b0, rd_addr_c} == (n_out - (ADDR_W+1)'(1)));
        rd_en_c   = req && (state == READY) && !clear && !rst;
        wr_ok_c   = wr_en && (state != READY) && (n_out < (ADDR_W+1)'(DEPTH))
                    && !clear && !rst;
    end

    sample_feeder_mem #(
        .W      (W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_ok_c),
        .wr_addr (n_out[ADDR_W-1:0]),
        .wr_data ({wr_x1, wr_x2, wr_t}),
        .re      (rd_en_c),
        .rd_addr (rd_addr_c),
        .rd_data (rd_data)
    );

    assign x1_out = rd_data[W-1 -: X_W];
    assign x2_out = rd_data[X_W:1];
    assign t_out  = rd_data[0];

    // Control FSM; clear behaves like reset for everything except the served sample.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state <= EMPTY;
            rptr  <= '0;
            n_out <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            ready <= 1'b0;
            err   <= 1'b0;
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
            epoch_cnt <= '0;
`endif
        end else begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (rewind) begin
                rptr <= '0;
            end
            case (state)
                EMPTY: begin
                    if (wr_en) begin
                        n_out <= n_out + (ADDR_W+1)'(1);
                        state <= FILL;
                    end else if (commit) begin
                        err <= 1'b1;
                    end
                    if (req) begin
                        err <= 1'b1;
                    end
                end
                FILL: begin
                    // A commit coinciding with a write is dropped.
                    if (wr_en) begin
                        if (wr_ok_c) begin
                            n_out <= n_out + (ADDR_W+1)'(1);
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (commit) begin
                        state <= READY;
                        ready <= 1'b1;
                        rptr  <= '0;
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
                        epoch_cnt <= '0;
`endif
                    end
                    if (req) begin
                        err <= 1'b1;
                    end
                end
                READY: begin
                    if (wr_en) begin
                        err <= 1'b1;
                    end
                    if (req) begin
                        valid <= 1'b1;
                        last  <= at_end_c;
                        rptr  <= at_end_c ? '0 : rd_addr_c + ADDR_W'(1);
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
                        if (at_end_c && (epoch_cnt != {EPOCH_W{1'b1}})) begin
                            epoch_cnt <= epoch_cnt + EPOCH_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_feeder.sv
// Directed, scoreboarded bench for sample_feeder (default parameters).
module tb_sample_feeder;
    import sample_feeder_pkg::*;

    typedef struct packed {
        sample_t s;
        logic    last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, clear, wr_en, wr_t, commit, req, rewind;
    logic [15:0] wr_x1, wr_x2;
    logic [15:0] x1_out, x2_out;
    logic        t_out, valid, last, ready, err;
    logic [6:0]  n_out;
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
    logic [15:0] epoch_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Bench-side reference of what the host has loaded and where serving stands.
    sample_t m_mem [64];
    int      m_n     = 0;
    int      m_rptr  = 0;
    bit      m_ready = 1'b0;
    bit      exp_v   = 1'b0;
    exp_t    sb [$];

    sample_feeder dut (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .wr_en  (wr_en),
        .wr_x1  (wr_x1),
        .wr_x2  (wr_x2),
        .wr_t   (wr_t),
        .commit (commit),
        .req    (req),
        .rewind (rewind),
        .x1_out (x1_out),
        .x2_out (x2_out),
        .t_out  (t_out),
        .valid  (valid),
        .last   (last),
        .ready  (ready),
        .n_out  (n_out),
`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
        .epoch_cnt (epoch_cnt),
`endif
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then check valid and any served sample against the scoreboard.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        chk("valid", 32'(valid), 32'(exp_v));
        if (valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            chk("x1_out", 32'(x1_out), 32'(e.s.x1));
            chk("x2_out", 32'(x2_out), 32'(e.s.x2));
            chk("t_out",  32'(t_out),  32'(e.s.t));
            chk("last",   32'(last),   32'(e.last));
        end
        exp_v = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] b, input logic t);
        wr_en = 1'b1; wr_x1 = a; wr_x2 = b; wr_t = t;
        if (!m_ready && m_n < 64) begin
            m_mem[m_n] = '{x1: a, x2: b, t: t};
            m_n++;
        end
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        if (!m_ready && m_n > 0) begin
            m_ready = 1'b1;
            m_rptr  = 0;
        end
        tick();
        commit = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        m_n = 0; m_rptr = 0; m_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic serve(input bit rw);
        exp_t e;
        req = 1'b1; rewind = rw;
        if (rw) m_rptr = 0;
        if (m_ready) begin
            e.s    = m_mem[m_rptr];
            e.last = (m_rptr == m_n - 1);
            sb.push_back(e);
            exp_v  = 1'b1;
            m_rptr = (m_rptr == m_n - 1) ? 0 : m_rptr + 1;
        end
        tick();
        req = 1'b0; rewind = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; wr_en = 1'b0; wr_t = 1'b0; commit = 1'b0;
        req = 1'b0; rewind = 1'b0; wr_x1 = '0; wr_x2 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_x1",    32'(x1_out), 32'd0);
        chk("rst_t",     32'(t_out),  32'd0);
        chk("rst_last",  32'(last),   32'd0);
        chk("rst_ready", 32'(ready),  32'd0);
        chk("rst_n",     32'(n_out),  32'd0);
        chk("rst_err",   32'(err),    32'd0);

        // Three samples, four fetches: 0,1,2,0 with last only on index 2.
        wr(16'd5, 16'hFFFE, 1'b1);
        wr(16'd7, 16'd3,    1'b0);
        wr(16'hFFFF, 16'hFFFF, 1'b1);
        do_commit();
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_n",     32'(n_out), 32'd3);
        for (int i = 0; i < 4; i++) serve(1'b0);
        tick();
        chk("t1_hold_x1", 32'(x1_out), 32'd5);
        chk("t1_err",     32'(err),    32'd0);

        // Overfill: 64 writes then one extra dropped.
        do_clear();
        chk("t2_clr_n", 32'(n_out), 32'd0);
        for (int i = 0; i < 64; i++) wr(16'(i + 100), 16'(i), 1'(i));
        chk("t2_err_before", 32'(err), 32'd0);
        wr(16'd999, 16'd999, 1'b0);
        chk("t2_n",   32'(n_out), 32'd64);
        chk("t2_err", 32'(err),   32'd1);
        do_commit();
        for (int i = 0; i < 64; i++) serve(1'b0);
        chk("t2_last_x1", 32'(x1_out), 32'd163);

        // Rewind alone, then rewind together with req.
        do_clear();
        chk("t3_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 4; i++) wr(16'(10 + i), 16'(20 + i), 1'(i));
        do_commit();
        serve(1'b0); serve(1'b0);
        rewind = 1'b1; m_rptr = 0;
        tick();
        rewind = 1'b0;
        chk("t3_rewind_hold", 32'(x1_out), 32'd11);
        serve(1'b0);
        serve(1'b1);
        serve(1'b0);
        chk("t3_x1_after", 32'(x1_out), 32'd11);

        // req before commit, then clear; then commit in EMPTY.
        do_clear();
        wr(16'd1, 16'd2, 1'b0);
        wr(16'd3, 16'd4, 1'b1);
        serve(1'b0);
        chk("t4_err", 32'(err), 32'd1);
        do_clear();
        chk("t4_err_clr", 32'(err),   32'd0);
        chk("t4_n_clr",   32'(n_out), 32'd0);
        chk("t4_ready",   32'(ready), 32'd0);
        do_commit();
        chk("t4_empty_commit_err", 32'(err), 32'd1);

        // Reset while a fetch is in flight suppresses the response.
        do_clear();
        for (int i = 0; i < 3; i++) wr(16'(30 + i), 16'(i), 1'b1);
        do_commit();
        req = 1'b1; rst = 1'b1;
        tick();
        req = 1'b0;
        tick();
        rst = 1'b0;
        m_n = 0; m_rptr = 0; m_ready = 1'b0;
        tick();
        chk("t5_ready", 32'(ready),  32'd0);
        chk("t5_n",     32'(n_out),  32'd0);
        chk("t5_x1",    32'(x1_out), 32'd0);

        // Single sample: every fetch is sample 0 with last.
        wr(16'd77, 16'd88, 1'b1);
        do_commit();
        for (int i = 0; i < 3; i++) serve(1'b0);

`ifdef SAMPLE_FEEDER_EPOCH_CNT_EN
        do_clear();
        wr(16'd1, 16'd1, 1'b0);
        wr(16'd2, 16'd2, 1'b1);
        do_commit();
        chk("t6_epoch0", 32'(epoch_cnt), 32'd0);
        for (int i = 0; i < 7; i++) serve(1'b0);
        tick();
        chk("t6_epoch3", 32'(epoch_cnt), 32'd3);
        rewind = 1'b1; m_rptr = 0;
        tick();
        rewind = 1'b0;
        chk("t6_rewind_keep", 32'(epoch_cnt), 32'd3);
        do_clear();
        wr(16'd5, 16'd5, 1'b0);
        wr(16'd6, 16'd6, 1'b0);
        do_commit();
        chk("t6_epoch_commit", 32'(epoch_cnt), 32'd0);
`endif

        tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
